// File: rtl/gshare_branch_predictor_if.sv
`default_nettype none
// ============================================================================
// Module      : gshare_branch_predictor_if
// Description : Decode-side prediction handshake and execute-side resolution
//               bus for the gshare branch predictor.
// Revision    : 1.0 - initial release
// ============================================================================
interface gshare_branch_predictor_if #(
  parameter int CKPT_BITS = 3
) ();
  // Decode request / response
  logic                 pred_req;
  logic                 pred_stall;
  logic [31:0]          pred_pc;
  logic                 pred_taken;
  logic                 pred_ack;
  logic [CKPT_BITS-1:0] pred_id;
  logic                 ckpt_full;
  // Execute resolution
  logic                 upd_valid;
  logic [CKPT_BITS-1:0] upd_id;
  logic                 upd_outcome;
  logic                 upd_mispredict;

  modport master (
    output pred_req, pred_stall, pred_pc,
    output upd_valid, upd_id, upd_outcome, upd_mispredict,
    input  pred_taken, pred_ack, pred_id, ckpt_full
  );

  modport slave (
    input  pred_req, pred_stall, pred_pc,
    input  upd_valid, upd_id, upd_outcome, upd_mispredict,
    output pred_taken, pred_ack, pred_id, ckpt_full
  );
endinterface
`default_nettype wire

// File: rtl/gshare_branch_predictor.sv
`default_nettype none
// ============================================================================
// Module      : gshare_branch_predictor
// Description : Gshare direction predictor (2-bit counters indexed by PC xor
//               global history) with a FIFO of GHR checkpoints used to train
//               counters in order and repair history on a mispredict.
// Revision    : 1.0 - initial release
// ============================================================================
module gshare_branch_predictor #(
  parameter int GHR_LEN    = 8,
  parameter int INDEX_BITS = 10,
  parameter int CKPT_BITS  = 3
) (
  input  logic                         clk,
  input  logic                         rst_n,
  output logic                         init_done,
  gshare_branch_predictor_if.slave     bus,
  output logic [GHR_LEN-1:0]           ghr,
  output logic                         order_err
);

  localparam int                 c_DEPTH = 1 << INDEX_BITS;
  localparam int                 c_SLOTS = 1 << CKPT_BITS;
  localparam logic [CKPT_BITS:0] c_FULL  = {1'b1, {CKPT_BITS{1'b0}}};

  localparam logic [0:0] c_ST_INIT = 1'b0;
  localparam logic [0:0] c_ST_RUN  = 1'b1;

  logic [0:0]            r_state;
  logic [INDEX_BITS-1:0] r_sweep;
  logic [1:0]            r_pht      [c_DEPTH];
  logic [GHR_LEN-1:0]    r_ckpt_ghr [c_SLOTS];
  logic [INDEX_BITS-1:0] r_ckpt_idx [c_SLOTS];
  logic [CKPT_BITS-1:0]  r_alloc_ptr;
  logic [CKPT_BITS-1:0]  r_head_ptr;
  logic [CKPT_BITS:0]    r_count;
  logic [GHR_LEN-1:0]    r_ghr;
  logic                  r_order_err;

  logic                  w_run;
  logic [INDEX_BITS-1:0] w_ghr_ext;
  logic [INDEX_BITS-1:0] w_idx;
  logic                  w_pred_taken;
  logic                  w_full;
  logic                  w_ack;
  logic                  w_upd_bad;
  logic                  w_upd_ok;
  logic [INDEX_BITS-1:0] w_upd_idx;
  logic [1:0]            w_cnt_cur;
  logic [1:0]            w_cnt_next;
  logic                  w_unused_pc;

  assign w_run       = (r_state == c_ST_RUN);
  assign w_full      = (r_count == c_FULL);
  assign w_idx       = bus.pred_pc[INDEX_BITS+1:2] ^ w_ghr_ext;
  assign w_unused_pc = ^{bus.pred_pc[31:INDEX_BITS+2], bus.pred_pc[1:0]};

  // Zero-extend the history to index width (history may be as wide as index)
  always_comb begin
    w_ghr_ext              = '0;
    w_ghr_ext[GHR_LEN-1:0] = r_ghr;
  end

  // Prediction, commit qualification and update classification
  always_comb begin
    w_pred_taken = w_run & r_pht[w_idx][1];
    // A mispredict flush this cycle wins over any new commit, even one that
    // arrives with an out-of-order id; decode re-presents after the flush.
    w_ack        = w_run & bus.pred_req & ~bus.pred_stall & ~w_full
                 & ~(bus.upd_valid & bus.upd_mispredict);
    w_upd_bad    = w_run & bus.upd_valid
                 & ((bus.upd_id != r_head_ptr) | (r_count == '0));
    w_upd_ok     = w_run & bus.upd_valid & ~w_upd_bad;
    w_upd_idx    = r_ckpt_idx[bus.upd_id];
    w_cnt_cur    = r_pht[w_upd_idx];
    w_cnt_next   = w_cnt_cur;
    if (bus.upd_outcome && w_cnt_cur != 2'b11) begin
      w_cnt_next = w_cnt_cur + 2'd1;
    end else if (!bus.upd_outcome && w_cnt_cur != 2'b00) begin
      w_cnt_next = w_cnt_cur - 2'd1;
    end
  end

  assign bus.pred_taken = w_pred_taken;
  assign bus.pred_ack   = w_ack;
  assign bus.pred_id    = r_alloc_ptr;
  assign bus.ckpt_full  = w_full;
  assign init_done      = w_run;
  assign ghr            = r_ghr;
  assign order_err      = r_order_err;

  // Pattern table: sweep to weakly-not-taken during INIT, then train on updates
  always_ff @(posedge clk) begin
    if (!w_run) begin
      r_pht[r_sweep] <= 2'b01;
    end else if (w_upd_ok) begin
      r_pht[w_upd_idx] <= w_cnt_next;
    end
  end

  // Checkpoint store: history and table index captured at commit
  always_ff @(posedge clk) begin
    if (w_ack) begin
      r_ckpt_ghr[r_alloc_ptr] <= r_ghr;
      r_ckpt_idx[r_alloc_ptr] <= w_idx;
    end
  end

  // Control state: init sweep, speculative history and checkpoint FIFO pointers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= c_ST_INIT;
      r_sweep     <= '0;
      r_ghr       <= '0;
      r_alloc_ptr <= '0;
      r_head_ptr  <= '0;
      r_count     <= '0;
      r_order_err <= 1'b0;
    end else begin
      if (!w_run) begin
        r_sweep <= r_sweep + 1'b1;
        if (r_sweep == {INDEX_BITS{1'b1}}) begin
          r_state <= c_ST_RUN;
        end
      end
      if (w_upd_bad) begin
        r_order_err <= 1'b1;
      end
      if (w_upd_ok && bus.upd_mispredict) begin
        // Rebuild history as it would have been with the correct direction and
        // squash every younger checkpoint.
        r_ghr       <= {r_ckpt_ghr[bus.upd_id][GHR_LEN-2:0], bus.upd_outcome};
        r_alloc_ptr <= bus.upd_id + 1'b1;
        r_head_ptr  <= bus.upd_id + 1'b1;
        r_count     <= '0;
      end else begin
        if (w_ack) begin
          r_ghr       <= {r_ghr[GHR_LEN-2:0], w_pred_taken};
          r_alloc_ptr <= r_alloc_ptr + 1'b1;
        end
        if (w_upd_ok) begin
          r_head_ptr <= r_head_ptr + 1'b1;
        end
        case ({w_ack, w_upd_ok})
          2'b10:   r_count <= r_count + 1'b1;
          2'b01:   r_count <= r_count - 1'b1;
          default: r_count <= r_count;
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_gshare_branch_predictor.sv
`default_nettype none
// ============================================================================
// Module      : tb_gshare_branch_predictor
// Description : Directed table-driven bench for gshare_branch_predictor.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gshare_branch_predictor;

  logic       clk;
  logic       rst_n;
  logic       init_done;
  logic [7:0] ghr;
  logic       order_err;

  int checks;
  int errors;

  gshare_branch_predictor_if #(.CKPT_BITS(3)) bus ();

  gshare_branch_predictor #(
    .GHR_LEN   (8),
    .INDEX_BITS(10),
    .CKPT_BITS (3)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .init_done(init_done),
    .bus      (bus),
    .ghr      (ghr),
    .order_err(order_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        pre_rst;
    logic        req;
    logic        stall;
    logic [31:0] pc;
    logic        uv;
    logic [2:0]  uid;
    logic        uo;
    logic        um;
    logic        e_taken;
    logic        e_ack;
    logic [2:0]  e_id;
    logic        e_full;
    logic [7:0]  e_ghr;
    logic        e_oe;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic pre, input logic req, input logic stall,
                     input logic [31:0] pc, input logic uv, input logic [2:0] uid,
                     input logic uo, input logic um, input logic t, input logic a,
                     input logic [2:0] id, input logic f, input logic [7:0] g,
                     input logic oe);
    vec_t v;
    v.pre_rst = pre; v.req = req; v.stall = stall; v.pc = pc;
    v.uv = uv; v.uid = uid; v.uo = uo; v.um = um;
    v.e_taken = t; v.e_ack = a; v.e_id = id; v.e_full = f; v.e_ghr = g; v.e_oe = oe;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reset, optionally re-reset 500 cycles into INIT, then time the sweep.
  // Decode and execute are kept busy during INIT; both must be ignored.
  task automatic do_reset(input bit restart);
    int n;
    bus.pred_req = 1'b1; bus.pred_stall = 1'b0; bus.pred_pc = 32'h100;
    bus.upd_valid = 1'b1; bus.upd_id = 3'd5; bus.upd_outcome = 1'b1;
    bus.upd_mispredict = 1'b1;
    @(posedge clk); #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    chk("init_done after reset", {31'd0, init_done}, 32'd0);
    if (restart) begin
      repeat (500) @(posedge clk);
      #1 rst_n = 1'b0;
      @(posedge clk); #1 rst_n = 1'b1;
      chk("init_done after mid-init reset", {31'd0, init_done}, 32'd0);
    end
    n = 0;
    while (!init_done && n < 2000) begin
      bus.pred_pc = $urandom;
      @(negedge clk);
      if (n % 256 == 0) begin
        chk("init pred_taken", {31'd0, bus.pred_taken}, 32'd0);
        chk("init pred_ack", {31'd0, bus.pred_ack}, 32'd0);
      end
      @(posedge clk); #1;
      n++;
    end
    chk("init duration cycles", n, 32'd1024);
    chk("init order_err", {31'd0, order_err}, 32'd0);
    chk("run ghr after init", {24'd0, ghr}, 32'd0);
  endtask

  localparam logic [31:0] A = 32'h0000_0100;

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    bus.pred_req = 1'b0; bus.pred_stall = 1'b0; bus.pred_pc = '0;
    bus.upd_valid = 1'b0; bus.upd_id = '0; bus.upd_outcome = 1'b0;
    bus.upd_mispredict = 1'b0;

    //  pre req st pc  uv id uo um | tk ack id full ghr  oe
    // Training 01->10->11 on pc 0x100, then history shift and stall
    add(1, 1, 0, A, 0, 0, 0, 0,   0, 1, 0, 0, 8'h00, 0);
    add(0, 1, 0, A, 0, 0, 0, 0,   0, 1, 1, 0, 8'h00, 0);
    add(0, 1, 0, A, 0, 0, 0, 0,   0, 1, 2, 0, 8'h00, 0);
    add(0, 0, 0, A, 1, 0, 1, 0,   0, 0, 0, 0, 8'h00, 0);
    add(0, 0, 0, A, 1, 1, 1, 0,   1, 0, 0, 0, 8'h00, 0);
    add(0, 0, 0, A, 1, 2, 1, 0,   1, 0, 0, 0, 8'h00, 0);
    add(0, 1, 0, A, 0, 0, 0, 0,   1, 1, 3, 0, 8'h00, 0);
    add(0, 0, 0, A, 0, 0, 0, 0,   0, 0, 0, 0, 8'h01, 0);
    add(0, 1, 1, A, 0, 0, 0, 0,   0, 0, 0, 0, 8'h01, 0);
    add(0, 1, 1, A, 0, 0, 0, 0,   0, 0, 0, 0, 8'h01, 0);
    add(0, 1, 1, A, 0, 0, 0, 0,   0, 0, 0, 0, 8'h01, 0);
    add(0, 1, 0, A, 0, 0, 0, 0,   0, 1, 4, 0, 8'h01, 0);
    add(0, 0, 0, A, 0, 0, 0, 0,   0, 0, 0, 0, 8'h02, 0);
    // Mispredict repair with a blocked same-cycle commit
    add(1, 1, 0, A, 0, 0, 0, 0,   0, 1, 0, 0, 8'h00, 0);
    add(0, 1, 0, A, 0, 0, 0, 0,   0, 1, 1, 0, 8'h00, 0);
    add(0, 1, 0, A, 0, 0, 0, 0,   0, 1, 2, 0, 8'h00, 0);
    add(0, 1, 0, A, 0, 0, 0, 0,   0, 1, 3, 0, 8'h00, 0);
    add(0, 0, 0, A, 1, 0, 0, 0,   0, 0, 0, 0, 8'h00, 0);
    add(0, 1, 0, A, 1, 1, 1, 1,   0, 0, 0, 0, 8'h00, 0);
    add(0, 1, 0, A, 0, 0, 0, 0,   0, 1, 2, 0, 8'h01, 0);
    add(0, 0, 0, A, 0, 0, 0, 0,   0, 0, 0, 0, 8'h02, 0);
    // Fill all eight slots, refuse, wrap, then an out-of-order update
    add(1, 1, 0, A, 0, 0, 0, 0,   0, 1, 0, 0, 8'h00, 0);
    for (int k = 1; k < 8; k++)
      add(0, 1, 0, A, 0, 0, 0, 0, 0, 1, 3'(k), 0, 8'h00, 0);
    add(0, 1, 0, A, 0, 0, 0, 0,   0, 0, 0, 1, 8'h00, 0);
    add(0, 1, 0, A, 1, 0, 0, 0,   0, 0, 0, 1, 8'h00, 0);
    add(0, 1, 0, A, 0, 0, 0, 0,   0, 1, 0, 0, 8'h00, 0);
    add(0, 0, 0, A, 1, 1, 0, 0,   0, 0, 0, 1, 8'h00, 0);
    add(0, 0, 0, A, 1, 4, 1, 1,   0, 0, 0, 0, 8'h00, 0);
    add(0, 1, 0, A, 0, 0, 0, 0,   0, 1, 1, 0, 8'h00, 1);
    add(0, 1, 0, A, 0, 0, 0, 0,   0, 0, 0, 1, 8'h00, 1);
    // Reset clears order_err; update with nothing live is an order error
    add(1, 0, 0, A, 1, 0, 1, 0,   0, 0, 0, 0, 8'h00, 0);
    add(0, 0, 0, A, 0, 0, 0, 0,   0, 0, 0, 0, 8'h00, 1);

    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].pre_rst) do_reset(i == 0);
      bus.pred_req       = vecs[i].req;
      bus.pred_stall     = vecs[i].stall;
      bus.pred_pc        = vecs[i].pc;
      bus.upd_valid      = vecs[i].uv;
      bus.upd_id         = vecs[i].uid;
      bus.upd_outcome    = vecs[i].uo;
      bus.upd_mispredict = vecs[i].um;
      @(negedge clk);
      chk($sformatf("v%0d pred_taken", i), {31'd0, bus.pred_taken}, {31'd0, vecs[i].e_taken});
      chk($sformatf("v%0d pred_ack", i), {31'd0, bus.pred_ack}, {31'd0, vecs[i].e_ack});
      if (vecs[i].e_ack)
        chk($sformatf("v%0d pred_id", i), {29'd0, bus.pred_id}, {29'd0, vecs[i].e_id});
      chk($sformatf("v%0d ckpt_full", i), {31'd0, bus.ckpt_full}, {31'd0, vecs[i].e_full});
      chk($sformatf("v%0d ghr", i), {24'd0, ghr}, {24'd0, vecs[i].e_ghr});
      chk($sformatf("v%0d order_err", i), {31'd0, order_err}, {31'd0, vecs[i].e_oe});
      @(posedge clk); #1;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
